// File: rtl/cpu_state_unit_if.sv
// ============================================================================
// Module      : cpu_state_unit_if
// Description : Bus between make_next_reg (master) and cpu_state_unit (slave):
//               load port, next-state/write request and architectural state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_state_unit_if #(
    parameter int MEMSIZE = 64
) ();
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_addr;
    logic [7:0]  load_data;
    logic        start;

    logic [7:0]  memory [0:MEMSIZE-1];
    logic [7:0]  a, b, c, d, sp, ip;
    logic        zf;

    logic [7:0]  next_a, next_b, next_c, next_d, next_sp, next_ip;
    logic        next_zf;
    logic        write_flag;
    logic [7:0]  write_addr;
    logic [7:0]  write_value;

    logic        running, halted, fault;
    logic [15:0] cycle_count;

    modport master (
        output load_valid, load_addr, load_data, start,
        output next_a, next_b, next_c, next_d, next_sp, next_ip, next_zf,
        output write_flag, write_addr, write_value,
        input  load_ready, memory, a, b, c, d, sp, ip, zf,
        input  running, halted, fault, cycle_count
    );

    modport slave (
        input  load_valid, load_addr, load_data, start,
        input  next_a, next_b, next_c, next_d, next_sp, next_ip, next_zf,
        input  write_flag, write_addr, write_value,
        output load_ready, memory, a, b, c, d, sp, ip, zf,
        output running, halted, fault, cycle_count
    );
endinterface

`default_nettype wire

// File: rtl/cpu_state_unit.sv
// ============================================================================
// Module      : cpu_state_unit
// Description : Architectural state (memory, a/b/c/d/sp/ip/zf) with byte-load
//               port and IDLE/RUN/HALT/FAULT control. Optional single-step
//               input enabled by defining CPU_SINGLE_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_state_unit #(
    parameter int         MEMSIZE = 64,
    parameter logic [7:0] SP_INIT = 8'd64
) (
    input  wire logic        clk,
    input  wire logic        rst,
`ifdef CPU_SINGLE_STEP_EN
    input  wire logic        step,
`endif
    cpu_state_unit_if.slave  bus
);
    localparam int         c_AW      = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam logic [8:0] c_MEMSIZE = 9'(MEMSIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_mem [0:MEMSIZE-1];
    logic [7:0]  r_a, r_b, r_c, r_d, r_sp, r_ip;
    logic        r_zf;
    logic [15:0] r_cycle_count;
    logic        r_running, r_halted, r_fault, r_load_ready;

    logic w_step;
    logic w_ip_oob;
    logic w_wr_oob;
    logic w_halt;
    logic w_load_ok;

`ifdef CPU_SINGLE_STEP_EN
    assign w_step = step;
`else
    assign w_step = 1'b1;
`endif

    assign w_ip_oob  = ({1'b0, r_ip} >= c_MEMSIZE);
    assign w_wr_oob  = bus.write_flag && ({1'b0, bus.write_addr} >= c_MEMSIZE);
    assign w_halt    = (bus.next_ip == r_ip) && !bus.write_flag;
    assign w_load_ok = bus.load_valid && ({1'b0, bus.load_addr} < c_MEMSIZE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_a           <= 8'h00;
            r_b           <= 8'h00;
            r_c           <= 8'h00;
            r_d           <= 8'h00;
            r_sp          <= SP_INIT;
            r_ip          <= 8'h00;
            r_zf          <= 1'b0;
            r_cycle_count <= 16'h0000;
            r_running     <= 1'b0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
            r_load_ready  <= 1'b1;
            for (int i = 0; i < MEMSIZE; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load_ok) begin
                        r_mem[bus.load_addr[c_AW-1:0]] <= bus.load_data;
                    end
                    if (bus.start) begin
                        r_state       <= S_RUN;
                        r_cycle_count <= 16'h0000;
                        r_running     <= 1'b1;
                        r_load_ready  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_step) begin
                        // Faults are checked before anything commits so the
                        // faulting cycle leaves registers and memory intact.
                        if (w_ip_oob || w_wr_oob) begin
                            r_state   <= S_FAULT;
                            r_running <= 1'b0;
                            r_fault   <= 1'b1;
                        end else begin
                            r_a  <= bus.next_a;
                            r_b  <= bus.next_b;
                            r_c  <= bus.next_c;
                            r_d  <= bus.next_d;
                            r_sp <= bus.next_sp;
                            r_ip <= bus.next_ip;
                            r_zf <= bus.next_zf;
                            if (r_cycle_count != 16'hFFFF) begin
                                r_cycle_count <= r_cycle_count + 16'd1;
                            end
                            if (w_halt) begin
                                r_state   <= S_HALT;
                                r_running <= 1'b0;
                                r_halted  <= 1'b1;
                            end else if (bus.write_flag) begin
                                r_mem[bus.write_addr[c_AW-1:0]] <= bus.write_value;
                            end
                        end
                    end
                end
                default: begin
                    // Restart keeps memory and cycle_count so a program reruns without reload.
                    if (bus.start) begin
                        r_state      <= S_IDLE;
                        r_a          <= 8'h00;
                        r_b          <= 8'h00;
                        r_c          <= 8'h00;
                        r_d          <= 8'h00;
                        r_sp         <= SP_INIT;
                        r_ip         <= 8'h00;
                        r_zf         <= 1'b0;
                        r_halted     <= 1'b0;
                        r_fault      <= 1'b0;
                        r_load_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.memory      = r_mem;
    assign bus.a           = r_a;
    assign bus.b           = r_b;
    assign bus.c           = r_c;
    assign bus.d           = r_d;
    assign bus.sp          = r_sp;
    assign bus.ip          = r_ip;
    assign bus.zf          = r_zf;
    assign bus.cycle_count = r_cycle_count;
    assign bus.running     = r_running;
    assign bus.halted      = r_halted;
    assign bus.fault       = r_fault;
    assign bus.load_ready  = r_load_ready;

endmodule

`default_nettype wire

// File: tb/tb_cpu_state_unit.sv
// ============================================================================
// Module      : tb_cpu_state_unit
// Description : Directed self-checking bench for cpu_state_unit; the bench
//               plays make_next_reg by driving hand-computed next_* values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_state_unit;
    logic clk;
    logic rst;
`ifdef CPU_SINGLE_STEP_EN
    logic step;
`endif
    int checks;
    int errors;

    cpu_state_unit_if #(.MEMSIZE(64)) bus ();

    cpu_state_unit #(
        .MEMSIZE (64),
        .SP_INIT (8'd64)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
`ifdef CPU_SINGLE_STEP_EN
        .step (step),
`endif
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_next(input logic [7:0] na, input logic [7:0] nb, input logic [7:0] nsp,
                            input logic [7:0] nip);
        bus.next_a  = na;
        bus.next_b  = nb;
        bus.next_c  = 8'h00;
        bus.next_d  = 8'h00;
        bus.next_sp = nsp;
        bus.next_ip = nip;
        bus.next_zf = 1'b0;
    endtask

    task automatic load(input logic [7:0] addr, input logic [7:0] data);
        bus.load_valid = 1'b1;
        bus.load_addr  = addr;
        bus.load_data  = data;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
`ifdef CPU_SINGLE_STEP_EN
        step = 1'b1;
`endif
        bus.load_valid  = 1'b0;
        bus.load_addr   = 8'h00;
        bus.load_data   = 8'h00;
        bus.start       = 1'b0;
        bus.write_flag  = 1'b0;
        bus.write_addr  = 8'h00;
        bus.write_value = 8'h00;
        set_next(8'h00, 8'h00, 8'd64, 8'h00);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_a", {8'h0, bus.a}, 16'h0000);
        check("rst_sp", {8'h0, bus.sp}, 16'h0040);
        check("rst_ip", {8'h0, bus.ip}, 16'h0000);
        check("rst_status", {13'h0, bus.running, bus.halted, bus.fault}, 16'h0000);
        check("rst_load_ready", {15'h0, bus.load_ready}, 16'h0001);
        check("rst_count", bus.cycle_count, 16'h0000);
        check("rst_mem63", {8'h0, bus.memory[63]}, 16'h0000);

        // T1: mov a,5 then halt
        load(8'h00, 8'h40);
        load(8'h01, 8'h05);
        load(8'h02, 8'hF0);
        check("t1_mem1", {8'h0, bus.memory[1]}, 16'h0005);
        pulse_start();
        check("t1_running", {13'h0, bus.running, bus.halted, bus.fault}, 16'h0004);
        check("t1_load_ready", {15'h0, bus.load_ready}, 16'h0000);
        set_next(8'h05, 8'h00, 8'd64, 8'h02);
        tick();
        check("t1_a", {8'h0, bus.a}, 16'h0005);
        check("t1_ip", {8'h0, bus.ip}, 16'h0002);
        check("t1_count1", bus.cycle_count, 16'h0001);
        tick();
        check("t1_halted", {13'h0, bus.running, bus.halted, bus.fault}, 16'h0002);
        check("t1_count2", bus.cycle_count, 16'h0002);
        // HALT freezes state and refuses loads
        set_next(8'h99, 8'h00, 8'd64, 8'h07);
        load(8'h00, 8'hAA);
        check("halt_frozen_a", {8'h0, bus.a}, 16'h0005);
        check("halt_no_load", {8'h0, bus.memory[0]}, 16'h0040);

        // T5: restart keeps memory and count, rerun is identical
        pulse_start();
        check("t5_idle_status", {13'h0, bus.running, bus.halted, bus.fault}, 16'h0000);
        check("t5_a_reinit", {8'h0, bus.a}, 16'h0000);
        check("t5_ip_reinit", {8'h0, bus.ip}, 16'h0000);
        check("t5_mem_kept", {8'h0, bus.memory[2]}, 16'h00F0);
        check("t5_count_kept", bus.cycle_count, 16'h0002);
        pulse_start();
        check("t5_count_cleared", bus.cycle_count, 16'h0000);
        set_next(8'h05, 8'h00, 8'd64, 8'h02);
        tick();
        tick();
        check("t5_rerun_a", {8'h0, bus.a}, 16'h0005);
        check("t5_rerun_status", {13'h0, bus.running, bus.halted, bus.fault}, 16'h0002);
        check("t5_rerun_count", bus.cycle_count, 16'h0002);

        // T2: mov b,7 ; push b ; halt
        pulse_start();
        load(8'h00, 8'h44);
        load(8'h01, 8'h07);
        load(8'h02, 8'h84);
        load(8'h03, 8'hF0);
        pulse_start();
        set_next(8'h00, 8'h07, 8'd64, 8'h02);
        tick();
        check("t2_b", {8'h0, bus.b}, 16'h0007);
        set_next(8'h00, 8'h07, 8'd63, 8'h03);
        bus.write_flag  = 1'b1;
        bus.write_addr  = 8'd63;
        bus.write_value = 8'h07;
        tick();
        bus.write_flag = 1'b0;
        check("t2_mem63", {8'h0, bus.memory[63]}, 16'h0007);
        check("t2_mem62", {8'h0, bus.memory[62]}, 16'h0000);
        check("t2_sp", {8'h0, bus.sp}, 16'h003F);
        tick();
        check("t2_halted", {13'h0, bus.running, bus.halted, bus.fault}, 16'h0002);
        check("t2_count", bus.cycle_count, 16'h0003);

        // T3: out-of-range write faults without committing
        pulse_start();
        pulse_start();
        set_next(8'h11, 8'h00, 8'd64, 8'h09);
        bus.write_flag  = 1'b1;
        bus.write_addr  = 8'd70;
        bus.write_value = 8'hEE;
        tick();
        bus.write_flag = 1'b0;
        check("t3_fault", {13'h0, bus.running, bus.halted, bus.fault}, 16'h0001);
        check("t3_a_unchanged", {8'h0, bus.a}, 16'h0000);
        check("t3_ip_unchanged", {8'h0, bus.ip}, 16'h0000);
        check("t3_mem63_kept", {8'h0, bus.memory[63]}, 16'h0007);
        check("t3_count", bus.cycle_count, 16'h0000);
        tick();
        check("t3_frozen_a", {8'h0, bus.a}, 16'h0000);

        // ip beyond memory faults on the following cycle
        pulse_start();
        pulse_start();
        set_next(8'h22, 8'h00, 8'd64, 8'd200);
        tick();
        check("ipoob_commit_ip", {8'h0, bus.ip}, 16'h00C8);
        check("ipoob_running", {13'h0, bus.running, bus.halted, bus.fault}, 16'h0004);
        set_next(8'h33, 8'h00, 8'd64, 8'd201);
        tick();
        check("ipoob_fault", {13'h0, bus.running, bus.halted, bus.fault}, 16'h0001);
        check("ipoob_ip_kept", {8'h0, bus.ip}, 16'h00C8);
        check("ipoob_a_kept", {8'h0, bus.a}, 16'h0022);
        check("ipoob_count", bus.cycle_count, 16'h0001);

        // T4: reset mid-RUN after three commits
        pulse_start();
        pulse_start();
        set_next(8'h01, 8'h00, 8'd64, 8'h02);
        tick();
        set_next(8'h02, 8'h00, 8'd64, 8'h04);
        tick();
        set_next(8'h03, 8'h00, 8'd64, 8'h06);
        tick();
        check("t4_count3", bus.cycle_count, 16'h0003);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_sp", {8'h0, bus.sp}, 16'h0040);
        check("t4_ip", {8'h0, bus.ip}, 16'h0000);
        check("t4_a", {8'h0, bus.a}, 16'h0000);
        check("t4_mem0", {8'h0, bus.memory[0]}, 16'h0000);
        check("t4_mem63", {8'h0, bus.memory[63]}, 16'h0000);
        check("t4_count", bus.cycle_count, 16'h0000);
        check("t4_status", {12'h0, bus.load_ready, bus.running, bus.halted, bus.fault}, 16'h0008);

        // Out-of-range load is dropped, not aliased
        load(8'd64, 8'hFF);
        check("load_oob_mem0", {8'h0, bus.memory[0]}, 16'h0000);

        // Load in the same cycle as start is still written
`ifdef CPU_SINGLE_STEP_EN
        step = 1'b0;
`endif
        bus.load_valid = 1'b1;
        bus.load_addr  = 8'h05;
        bus.load_data  = 8'h5A;
        bus.start      = 1'b1;
        set_next(8'h00, 8'h00, 8'd64, 8'h02);
        tick();
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
        check("load_start_mem5", {8'h0, bus.memory[5]}, 16'h005A);
        check("load_start_running", {13'h0, bus.running, bus.halted, bus.fault}, 16'h0004);

`ifdef CPU_SINGLE_STEP_EN
        // T6: step=0 holds all state, one step pulse commits once
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check("t6_ip_hold", {8'h0, bus.ip}, 16'h0000);
        check("t6_count_hold", bus.cycle_count, 16'h0000);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("t6_ip_step", {8'h0, bus.ip}, 16'h0002);
        check("t6_count_step", bus.cycle_count, 16'h0001);
        tick();
        check("t6_ip_after", {8'h0, bus.ip}, 16'h0002);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
